// File: rtl/vram_write_arbiter_if.sv
// Request side of the VRAM write arbiter: three packed write requesters
// sharing one valid/ready handshake bundle.
interface vram_write_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
);
    logic [2:0]          req_valid;
    logic [3*ADDR_W-1:0] req_addr;
    logic [3*DATA_W-1:0] req_data;
    logic [2:0]          req_ready;

    modport master (output req_valid, output req_addr, output req_data, input req_ready);
    modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/vram_write_arbiter.sv
// Round-robin arbiter sharing the text-mode VRAM write port between the board
// loader, the UART console and the UI overlay, with bursts capped at BURST_MAX.
module vram_write_arbiter #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 16,
    parameter int VRAM_DEPTH = 4096,
    parameter int BURST_MAX  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pause,
    vram_write_arbiter_if.slave   req,
    output logic [ADDR_W-1:0]     waddr,
    output logic [DATA_W-1:0]     wdata,
    output logic                  wr,
    output logic [1:0]            grant_id,
    output logic [7:0]            drop_count,
    output logic                  busy
);

    localparam int BEAT_W = $clog2(BURST_MAX) + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_MAX - 1);
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(VRAM_DEPTH);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state_q, state_d;
    logic [1:0]          owner_q, owner_d;
    logic [1:0]          rrPtr_q, rrPtr_d;
    logic [BEAT_W-1:0]   beatCnt_q, beatCnt_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [7:0]          dropCount_q, dropCount_d;

    logic [ADDR_W-1:0]   ownerAddr;
    logic [DATA_W-1:0]   ownerData;
    logic                ownerValid;
    logic [2:0]          reqReady;
    logic [3:0]          validExt;
    logic [1:0]          cand1, cand2, pick;
    logic                xfer, inRange;

    function automatic logic [1:0] nextIdx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Owner mux; ready is decoded only from registered state so it never depends on valid.
    always_comb begin
        ownerAddr  = '0;
        ownerData  = '0;
        ownerValid = 1'b0;
        reqReady   = '0;
        case (owner_q)
            2'd0: begin
                ownerAddr  = req.req_addr[0 +: ADDR_W];
                ownerData  = req.req_data[0 +: DATA_W];
                ownerValid = req.req_valid[0];
                reqReady   = 3'b001;
            end
            2'd1: begin
                ownerAddr  = req.req_addr[ADDR_W +: ADDR_W];
                ownerData  = req.req_data[DATA_W +: DATA_W];
                ownerValid = req.req_valid[1];
                reqReady   = 3'b010;
            end
            2'd2: begin
                ownerAddr  = req.req_addr[2*ADDR_W +: ADDR_W];
                ownerData  = req.req_data[2*DATA_W +: DATA_W];
                ownerValid = req.req_valid[2];
                reqReady   = 3'b100;
            end
            default: ;
        endcase
        if (state_q != GRANT || pause) begin
            reqReady = '0;
        end
    end

    assign xfer     = (state_q == GRANT) && !pause && ownerValid;
    assign inRange  = {1'b0, ownerAddr} < DEPTH_L;
    assign validExt = {1'b0, req.req_valid};
    assign cand1    = nextIdx(rrPtr_q);
    assign cand2    = nextIdx(cand1);
    assign pick     = validExt[rrPtr_q] ? rrPtr_q : (validExt[cand1] ? cand1 : cand2);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rrPtr_d   = rrPtr_q;
        beatCnt_d = beatCnt_q;
        case (state_q)
            IDLE: begin
                if (!pause && (|req.req_valid)) begin
                    state_d   = GRANT;
                    owner_d   = pick;
                    beatCnt_d = '0;
                end
            end
            GRANT: begin
                if (!pause) begin
                    if (ownerValid) begin
                        beatCnt_d = beatCnt_q + BEAT_W'(1);
                        if (beatCnt_q == LAST_BEAT) begin
                            state_d = IDLE;
                            rrPtr_d = nextIdx(owner_q);
                        end
                    end else begin
                        state_d = IDLE;
                        rrPtr_d = nextIdx(owner_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Out-of-range beats are still consumed so the requester advances, but only counted.
    always_comb begin
        wr_d        = xfer && inRange;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        dropCount_d = dropCount_q;
        if (xfer && inRange) begin
            waddr_d = ownerAddr;
            wdata_d = ownerData;
        end
        if (xfer && !inRange && dropCount_q != 8'hFF) begin
            dropCount_d = dropCount_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rrPtr_q     <= '0;
            beatCnt_q   <= '0;
            wr_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            dropCount_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rrPtr_q     <= rrPtr_d;
            beatCnt_q   <= beatCnt_d;
            wr_q        <= wr_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            dropCount_q <= dropCount_d;
        end
    end

    assign req.req_ready = reqReady;
    assign waddr         = waddr_q;
    assign wdata         = wdata_q;
    assign wr            = wr_q;
    assign grant_id      = (state_q == GRANT) ? owner_q : 2'd3;
    assign drop_count    = dropCount_q;
    assign busy          = (state_q == GRANT);

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed bench for vram_write_arbiter with BURST_MAX=4: streaming, rotation,
// fairness, out-of-range drops, pause and reset-during-transfer.
module tb_vram_write_arbiter;

    localparam int ADDR_W    = 13;
    localparam int DATA_W    = 16;
    localparam int BURST_MAX = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              pause;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              wr;
    logic [1:0]        grant_id;
    logic [7:0]        drop_count;
    logic              busy;

    int testCount = 0;
    int failCount = 0;

    logic [15:0] expMem [4096];
    bit          expSet [4096];
    bit          seen   [4096];

    always #5 clk = ~clk;

    vram_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) reqIf ();

    vram_write_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .VRAM_DEPTH(4096), .BURST_MAX(BURST_MAX)
    ) dut (
        .clk(clk), .rst(rst), .pause(pause), .req(reqIf),
        .waddr(waddr), .wdata(wdata), .wr(wr),
        .grant_id(grant_id), .drop_count(drop_count), .busy(busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int idx, input logic valid, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] data);
        reqIf.req_valid[idx] = valid;
        reqIf.req_addr[idx*ADDR_W +: ADDR_W] = addr;
        reqIf.req_data[idx*DATA_W +: DATA_W] = data;
    endtask

    task automatic doReset();
        rst             = 1'b1;
        pause           = 1'b0;
        reqIf.req_valid = '0;
        reqIf.req_addr  = '0;
        reqIf.req_data  = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int addr0, addr2, writes, badWrites, grantWait, fires, expG, pos, p2, b2;
        bit fire0, fire2, sawWr;

        // Test 1: reset values, single requester streaming five beats
        doReset();
        checkOutput("rst_wr", wr, 0);
        checkOutput("rst_waddr", waddr, 0);
        checkOutput("rst_wdata", wdata, 0);
        checkOutput("rst_drop", drop_count, 0);
        checkOutput("rst_grant", grant_id, 3);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ready", reqIf.req_ready, 0);

        applyStimulus(0, 1'b1, 13'd0, 16'h0FDB);
        tick();
        checkOutput("t1_grant", grant_id, 0);
        checkOutput("t1_ready", reqIf.req_ready, 3'b001);
        checkOutput("t1_wr0", wr, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("t1_wr", wr, 1);
            checkOutput("t1_waddr", waddr, k);
            checkOutput("t1_wdata", wdata, 16'h0FDB);
            applyStimulus(0, 1'b1, ADDR_W'(k + 1), 16'h0FDB);
        end
        checkOutput("t1_forced_release", grant_id, 3);
        tick();
        checkOutput("t1_bubble_wr", wr, 0);
        checkOutput("t1_regrant", grant_id, 0);
        tick();
        checkOutput("t1_wr4", wr, 1);
        checkOutput("t1_waddr4", waddr, 4);
        applyStimulus(0, 1'b0, 13'd0, 16'h0);
        tick();
        checkOutput("t1_idle_wr", wr, 0);
        checkOutput("t1_idle_grant", grant_id, 3);
        checkOutput("t1_idle_busy", busy, 0);

        // Test 2: all three valid, rotation 0,1,2,0 with 4 beats and one bubble each
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(i, 1'b1, ADDR_W'(256 + i*16), DATA_W'(16'hB000 + i));
        for (int c = 1; c <= 16; c++) begin
            tick();
            pos  = (c - 1) % 5;
            expG = (pos < 4) ? ((c - 1) / 5) % 3 : 3;
            checkOutput("t2_grant", grant_id, expG);
            if (c >= 2) begin
                p2 = (c - 2) % 5;
                b2 = ((c - 2) / 5) % 3;
                checkOutput("t2_wr", wr, (p2 < 4) ? 1 : 0);
                if (p2 < 4) begin
                    checkOutput("t2_waddr", waddr, 256 + b2*16);
                    checkOutput("t2_wdata", wdata, 16'hB000 + b2);
                end
            end
        end

        // Test 3: 1024-beat stream from requester 0 with UI writes joining mid-stream
        doReset();
        foreach (expSet[i]) begin
            expSet[i] = 1'b0;
            seen[i]   = 1'b0;
            expMem[i] = '0;
        end
        addr0 = 0; addr2 = 0; writes = 0; badWrites = 0; grantWait = -1;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            if (addr0 < 1024) begin
                applyStimulus(0, 1'b1, ADDR_W'(addr0), DATA_W'(addr0) ^ 16'hA5A5);
                expMem[addr0] = DATA_W'(addr0) ^ 16'hA5A5;
                expSet[addr0] = 1'b1;
            end else begin
                applyStimulus(0, 1'b0, 13'd0, 16'h0);
            end
            if (cyc >= 100 && addr2 < 8) begin
                applyStimulus(2, 1'b1, ADDR_W'(3000 + addr2), DATA_W'(16'hC000 + addr2));
                expMem[3000 + addr2] = DATA_W'(16'hC000 + addr2);
                expSet[3000 + addr2] = 1'b1;
            end else begin
                applyStimulus(2, 1'b0, 13'd0, 16'h0);
            end
            #1;
            fire0 = reqIf.req_ready[0] & reqIf.req_valid[0];
            fire2 = reqIf.req_ready[2] & reqIf.req_valid[2];
            tick();
            if (fire0) addr0++;
            if (fire2) addr2++;
            if (grantWait < 0 && cyc >= 100 && grant_id == 2'd2) grantWait = cyc - 100 + 1;
            if (wr) begin
                writes++;
                if (!expSet[waddr] || seen[waddr] || wdata !== expMem[waddr]) badWrites++;
                seen[waddr] = 1'b1;
            end
            if (addr0 == 1024 && addr2 == 8) break;
        end
        applyStimulus(0, 1'b0, 13'd0, 16'h0);
        applyStimulus(2, 1'b0, 13'd0, 16'h0);
        checkOutput("t3_req0_done", addr0, 1024);
        checkOutput("t3_req2_done", addr2, 8);
        checkOutput("t3_write_count", writes, 1032);
        checkOutput("t3_bad_writes", badWrites, 0);
        checkOutput("t3_ui_grant_bound", (grantWait >= 1 && grantWait <= BURST_MAX + 1) ? 1 : 0, 1);

        // Test 4: out-of-range writes are consumed, never written, and counted to 255
        doReset();
        applyStimulus(1, 1'b1, 13'h1FFF, 16'h7777);
        tick();
        checkOutput("t4_grant", grant_id, 1);
        checkOutput("t4_ready", reqIf.req_ready, 3'b010);
        tick();
        checkOutput("t4_wr", wr, 0);
        checkOutput("t4_drop1", drop_count, 1);
        fires = 1; sawWr = 1'b0;
        for (int cyc = 0; cyc < 1000 && fires < 300; cyc++) begin
            fire0 = reqIf.req_ready[1] & reqIf.req_valid[1];
            tick();
            if (fire0) fires++;
            if (wr) sawWr = 1'b1;
        end
        applyStimulus(1, 1'b0, 13'd0, 16'h0);
        tick();
        checkOutput("t4_fires", fires, 300);
        checkOutput("t4_no_wr", sawWr, 0);
        checkOutput("t4_drop_sat", drop_count, 255);

        // Test 5: pause mid-burst holds owner and beat count
        doReset();
        applyStimulus(0, 1'b1, 13'd10, 16'h5A00);
        tick();
        tick();
        checkOutput("t5_wr10", waddr, 10);
        applyStimulus(0, 1'b1, 13'd11, 16'h5A00);
        tick();
        checkOutput("t5_wr11", waddr, 11);
        applyStimulus(0, 1'b1, 13'd12, 16'h5A00);
        pause = 1'b1;
        #1;
        checkOutput("t5_pause_ready_now", reqIf.req_ready, 0);
        for (int p = 0; p < 10; p++) begin
            if (p == 3) applyStimulus(0, 1'b0, 13'd12, 16'h5A00);
            if (p == 6) applyStimulus(0, 1'b1, 13'd12, 16'h5A00);
            tick();
            checkOutput("t5_pause_ready", reqIf.req_ready, 0);
            checkOutput("t5_pause_wr", wr, 0);
            checkOutput("t5_pause_grant", grant_id, 0);
            checkOutput("t5_pause_waddr", waddr, 11);
        end
        pause = 1'b0;
        #1;
        checkOutput("t5_resume_ready", reqIf.req_ready, 3'b001);
        tick();
        checkOutput("t5_beat3_wr", wr, 1);
        checkOutput("t5_beat3_addr", waddr, 12);
        checkOutput("t5_beat3_grant", grant_id, 0);
        applyStimulus(0, 1'b1, 13'd13, 16'h5A00);
        tick();
        checkOutput("t5_beat4_wr", wr, 1);
        checkOutput("t5_beat4_addr", waddr, 13);
        checkOutput("t5_capped", grant_id, 3);
        applyStimulus(0, 1'b0, 13'd0, 16'h0);
        tick();
        checkOutput("t5_end_wr", wr, 0);

        // Test 6: reset coinciding with a transfer, and rr pointer back to 0
        doReset();
        applyStimulus(1, 1'b1, 13'd7, 16'h1234);
        tick();
        tick();
        checkOutput("t6_wr7", wr, 1);
        checkOutput("t6_waddr7", waddr, 7);
        applyStimulus(1, 1'b1, 13'h1FFF, 16'h9999);
        tick();
        checkOutput("t6_drop", drop_count, 1);
        applyStimulus(1, 1'b0, 13'd0, 16'h0);
        tick();
        checkOutput("t6_release", grant_id, 3);
        applyStimulus(1, 1'b1, 13'd20, 16'h2020);
        tick();
        checkOutput("t6_grant1", grant_id, 1);
        checkOutput("t6_ready1", reqIf.req_ready, 3'b010);
        rst = 1'b1;
        tick();
        checkOutput("t6_rst_wr", wr, 0);
        checkOutput("t6_rst_waddr", waddr, 0);
        checkOutput("t6_rst_wdata", wdata, 0);
        checkOutput("t6_rst_drop", drop_count, 0);
        checkOutput("t6_rst_grant", grant_id, 3);
        checkOutput("t6_rst_busy", busy, 0);
        checkOutput("t6_rst_ready", reqIf.req_ready, 0);
        rst = 1'b0;
        applyStimulus(0, 1'b1, 13'd30, 16'h3000);
        applyStimulus(2, 1'b1, 13'd32, 16'h3002);
        tick();
        checkOutput("t6_rr_reset", grant_id, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
